// File: rtl/rx_subcarrier_serializer_if.sv
// Demapper-to-IDFT link for the subcarrier serializer: parallel block in, serial samples out.
// The master modport is the environment side (upstream demapper plus downstream consumer).
interface rx_subcarrier_serializer_if #(
   parameter int N_SC   = 12,
   parameter int DATA_W = 16,
   parameter int TAG_W  = 3
);
   logic                         i_valid;
   logic [N_SC-1:0][DATA_W-1:0]  i_real;
   logic [N_SC-1:0][DATA_W-1:0]  i_imag;
   logic [TAG_W-1:0]             i_tag;
   logic                         i_ready;
   logic                         o_valid;
   logic signed [DATA_W-1:0]     o_real;
   logic signed [DATA_W-1:0]     o_imag;
   logic                         o_sop;
   logic                         o_eop;
   logic [TAG_W-1:0]             o_tag;
   logic                         o_in_ready;
   logic                         o_overflow;
   logic [7:0]                   o_drop_cnt;

   modport master (
      output i_valid, i_real, i_imag, i_tag, i_ready,
      input  o_valid, o_real, o_imag, o_sop, o_eop, o_tag, o_in_ready, o_overflow, o_drop_cnt
   );

   modport slave (
      input  i_valid, i_real, i_imag, i_tag, i_ready,
      output o_valid, o_real, o_imag, o_sop, o_eop, o_tag, o_in_ready, o_overflow, o_drop_cnt
   );
endinterface

// File: rtl/rx_subcarrier_serializer.sv
// Ping-pong buffer that captures parallel subcarrier blocks and streams them out
// one complex sample per cycle, dropping (and counting) blocks when both banks are busy.
module rx_subcarrier_serializer #(
   parameter int N_SC   = 12,
   parameter int DATA_W = 16,
   parameter int TAG_W  = 3
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   rx_subcarrier_serializer_if.slave  bus
);
   localparam int IDX_W = (N_SC > 1) ? $clog2(N_SC) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SC - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic               rd_ptr_reg, rd_ptr_next;
   logic               wr_ptr_reg;
   logic [1:0]         full_reg, full_next;
   logic               hs, last_hs, wr_ok, drop;

   logic [DATA_W-1:0]  mem_real [2][N_SC];
   logic [DATA_W-1:0]  mem_imag [2][N_SC];
   logic [TAG_W-1:0]   mem_tag  [2];

   logic [DATA_W-1:0]  real_reg, imag_reg;
   logic [TAG_W-1:0]   tag_reg;
   logic               sop_reg, eop_reg, overflow_reg;
   logic [7:0]         drop_cnt_reg;

   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      rd_ptr_next = rd_ptr_reg;
      hs          = (state_reg == STREAM) && bus.i_ready;
      last_hs     = hs && (idx_reg == IDX_LAST);

      case (state_reg)
         IDLE: begin
            if (full_reg[rd_ptr_reg]) begin
               state_next = STREAM;
               idx_next   = '0;
            end
         end
         STREAM: begin
            if (last_hs) begin
               idx_next    = '0;
               rd_ptr_next = ~rd_ptr_reg;
               // Chain straight into the other bank when it is already loaded.
               state_next  = full_reg[~rd_ptr_reg] ? STREAM : IDLE;
            end else if (hs) begin
               idx_next = idx_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // A bank being released by the final read handshake may be refilled in the same cycle.
      wr_ok     = bus.i_valid && (!full_reg[wr_ptr_reg] || (last_hs && (rd_ptr_reg == wr_ptr_reg)));
      drop      = bus.i_valid && !wr_ok;
      full_next = full_reg;
      if (last_hs) full_next[rd_ptr_reg] = 1'b0;
      if (wr_ok)   full_next[wr_ptr_reg] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg    <= IDLE;
         idx_reg      <= '0;
         rd_ptr_reg   <= 1'b0;
         wr_ptr_reg   <= 1'b0;
         full_reg     <= '0;
         real_reg     <= '0;
         imag_reg     <= '0;
         tag_reg      <= '0;
         sop_reg      <= 1'b0;
         eop_reg      <= 1'b0;
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         rd_ptr_reg   <= rd_ptr_next;
         wr_ptr_reg   <= wr_ptr_reg ^ wr_ok;
         full_reg     <= full_next;
         overflow_reg <= drop;
         if (drop && (drop_cnt_reg != 8'hFF)) drop_cnt_reg <= drop_cnt_reg + 8'd1;
         // Output data follows the next read position, so it holds naturally while stalled.
         if (state_next == STREAM) begin
            real_reg <= mem_real[rd_ptr_next][idx_next];
            imag_reg <= mem_imag[rd_ptr_next][idx_next];
            tag_reg  <= mem_tag[rd_ptr_next];
            sop_reg  <= (idx_next == '0);
            eop_reg  <= (idx_next == IDX_LAST);
         end else begin
            sop_reg  <= 1'b0;
            eop_reg  <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_ok) begin
         for (int k = 0; k < N_SC; k++) begin
            mem_real[wr_ptr_reg][k] <= bus.i_real[k];
            mem_imag[wr_ptr_reg][k] <= bus.i_imag[k];
         end
         mem_tag[wr_ptr_reg] <= bus.i_tag;
      end
   end

   assign bus.o_valid    = (state_reg == STREAM);
   assign bus.o_real     = real_reg;
   assign bus.o_imag     = imag_reg;
   assign bus.o_tag      = tag_reg;
   assign bus.o_sop      = sop_reg;
   assign bus.o_eop      = eop_reg;
   assign bus.o_overflow = overflow_reg;
   assign bus.o_drop_cnt = drop_cnt_reg;
   assign bus.o_in_ready = !full_reg[wr_ptr_reg];
endmodule

// File: tb/tb_rx_subcarrier_serializer.sv
// Directed self-checking bench for rx_subcarrier_serializer: single block, back-to-back,
// stalls, overflow, refill-on-free and mid-stream reset.
module tb_rx_subcarrier_serializer;
   localparam int N_SC   = 12;
   localparam int DATA_W = 16;
   localparam int TAG_W  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   rx_subcarrier_serializer_if #(.N_SC(N_SC), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   rx_subcarrier_serializer #(.N_SC(N_SC), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Block samples: real = base+k, imag = -(base+k).
   task automatic drive_block(input logic valid, input int tag, input int base);
      bus.i_valid = valid;
      bus.i_tag   = TAG_W'(tag);
      for (int k = 0; k < N_SC; k++) begin
         bus.i_real[k] = DATA_W'(base + k);
         bus.i_imag[k] = DATA_W'(-(base + k));
      end
   endtask

   task automatic check_sample(input string name, input int tag, input int base, input int k);
      chk({name, "_valid"}, bus.o_valid, 1);
      chk({name, "_real"},  bus.o_real, base + k);
      chk({name, "_imag"},  bus.o_imag, -(base + k));
      chk({name, "_sop"},   bus.o_sop, (k == 0) ? 1 : 0);
      chk({name, "_eop"},   bus.o_eop, (k == N_SC - 1) ? 1 : 0);
      chk({name, "_tag"},   bus.o_tag, tag);
   endtask

   // One isolated block with i_ready=1: first sample two cycles after i_valid.
   task automatic stream_single(input string name, input int tag, input int base);
      bus.i_ready = 1'b1;
      drive_block(1'b1, tag, base);
      tick();
      drive_block(1'b0, 0, 0);
      chk({name, "_lat1_valid"}, bus.o_valid, 0);
      tick();
      for (int k = 0; k < N_SC; k++) begin
         check_sample(name, tag, base, k);
         $display("%s sample %0d real=%0d imag=%0d", name, k, bus.o_real, bus.o_imag);
         tick();
      end
      chk({name, "_after_valid"}, bus.o_valid, 0);
   endtask

   initial begin
      int exp_idx;
      int j;
      bus.i_ready = 1'b1;
      drive_block(1'b0, 0, 0);

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid",    bus.o_valid, 0);
      chk("rst_sop",      bus.o_sop, 0);
      chk("rst_eop",      bus.o_eop, 0);
      chk("rst_overflow", bus.o_overflow, 0);
      chk("rst_real",     bus.o_real, 0);
      chk("rst_imag",     bus.o_imag, 0);
      chk("rst_tag",      bus.o_tag, 0);
      chk("rst_drop",     bus.o_drop_cnt, 0);
      chk("rst_in_ready", bus.o_in_ready, 1);
      tick();

      // Single block, tag 5, real=k imag=-k
      stream_single("single", 5, 0);

      // Two blocks 12 cycles apart: 24 samples, no bubble
      bus.i_ready = 1'b1;
      for (int c = 0; c < 28; c++) begin
         if (c == 0)       drive_block(1'b1, 1, 100);
         else if (c == 12) drive_block(1'b1, 4, 120);
         else              drive_block(1'b0, 0, 0);
         if (c >= 2 && c <= 25) begin
            j = c - 2;
            check_sample("b2b", (j < 12) ? 1 : 4, (j < 12) ? 100 : 120, j % 12);
            $display("b2b cycle %0d real=%0d tag=%0d", c, bus.o_real, bus.o_tag);
         end else begin
            chk("b2b_idle_valid", bus.o_valid, 0);
         end
         chk("b2b_overflow", bus.o_overflow, 0);
         tick();
      end

      // i_ready alternating: every sample held while stalled, delivered once in order
      drive_block(1'b1, 2, 200);
      tick();
      drive_block(1'b0, 0, 0);
      tick();
      exp_idx = 0;
      for (int c = 0; c < 40 && exp_idx < N_SC; c++) begin
         bus.i_ready = (c % 2 == 0);
         check_sample("stall", 2, 200, exp_idx);
         $display("stall cycle %0d ready=%0b real=%0d", c, bus.i_ready, bus.o_real);
         if (bus.i_ready) exp_idx++;
         tick();
      end
      chk("stall_all_delivered", exp_idx, N_SC);
      bus.i_ready = 1'b1;
      chk("stall_after_valid", bus.o_valid, 0);

      // i_ready=0, three blocks: third dropped
      bus.i_ready = 1'b0;
      drive_block(1'b1, 3, 300);
      tick();
      drive_block(1'b1, 4, 400);
      chk("ovf_in_ready_c1", bus.o_in_ready, 1);
      tick();
      drive_block(1'b1, 5, 500);
      chk("ovf_in_ready_c2", bus.o_in_ready, 0);
      chk("ovf_overflow_c2", bus.o_overflow, 0);
      tick();
      drive_block(1'b0, 0, 0);
      chk("ovf_overflow_c3", bus.o_overflow, 1);
      chk("ovf_drop_c3",     bus.o_drop_cnt, 1);
      chk("ovf_in_ready_c3", bus.o_in_ready, 0);
      $display("overflow cycle 3 overflow=%0b drop_cnt=%0d", bus.o_overflow, bus.o_drop_cnt);
      tick();
      chk("ovf_overflow_c4", bus.o_overflow, 0);
      check_sample("ovf_hold", 3, 300, 0);

      // Refill on free: new block in the same cycle as the final handshake of the first bank
      bus.i_ready = 1'b1;
      for (int c = 4; c < 42; c++) begin
         if (c == 15) drive_block(1'b1, 6, 600);
         else         drive_block(1'b0, 0, 0);
         j = c - 4;
         if (j < 36) begin
            case (j / 12)
               0:       check_sample("refill", 3, 300, j % 12);
               1:       check_sample("refill", 4, 400, j % 12);
               default: check_sample("refill", 6, 600, j % 12);
            endcase
            $display("refill cycle %0d real=%0d tag=%0d", c, bus.o_real, bus.o_tag);
         end else begin
            chk("refill_idle_valid", bus.o_valid, 0);
         end
         chk("refill_overflow", bus.o_overflow, 0);
         chk("refill_drop",     bus.o_drop_cnt, 1);
         tick();
      end

      // Reset at sample idx 6, with a simultaneous block that must be discarded
      drive_block(1'b1, 7, 700);
      tick();
      drive_block(1'b0, 0, 0);
      tick();
      for (int k = 0; k < 6; k++) tick();
      check_sample("prerst", 7, 700, 6);
      rst = 1'b1;
      drive_block(1'b1, 1, 900);
      tick();
      rst = 1'b0;
      drive_block(1'b0, 0, 0);
      chk("midrst_valid",    bus.o_valid, 0);
      chk("midrst_drop",     bus.o_drop_cnt, 0);
      chk("midrst_in_ready", bus.o_in_ready, 1);
      chk("midrst_overflow", bus.o_overflow, 0);
      $display("midrst valid=%0b drop_cnt=%0d in_ready=%0b", bus.o_valid, bus.o_drop_cnt, bus.o_in_ready);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("midrst_discard_valid", bus.o_valid, 0);
      end
      tick();
      stream_single("postrst", 2, 800);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
